pipe_array_mult: RTL and testbench

Parametrised, pipelined N×N array multiplier, the next generation of the team's fixed 4×4 combinational array multiplier. It keeps the same structure: AND-gate partial products, carry-save rows of half/full adders, and a final ripple row. The rows are cut into register stages, a per-operation signed/unsigned mode is added, and a valid/ready stream handshake with back-pressure is provided. It sits in the datapath as a one-result-per-cycle multiply unit.

---
 rtl/pipe_array_mult.sv | 175 +++++++++++++++++
 tb/tb_pipe_array_mult.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_array_mult.sv
`default_nettype none
// ============================================================================
// Module      : pipe_array_mult
// Description : Pipelined NxN Baugh-Wooley array multiplier with carry-save
//               rows, per-operation signed mode and valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_array_mult #(
    parameter int N     = 8,
    parameter int RPS   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             is_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   p,
    output logic [TAG_W-1:0] out_tag
);
    localparam int            S     = (N + RPS - 2) / RPS;
    localparam int            PW    = 2 * N;
    localparam logic [PW-1:0] C_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] C_BW  = (C_ONE << N) | (C_ONE << (PW - 1));
    localparam logic [N-1:0]  C_MSB = {1'b1, {(N-1){1'b0}}};

    logic             adv_en;
    logic             out_valid_q;
    logic [PW-1:0]    p_q;
    logic [TAG_W-1:0] out_tag_q;

    // The whole pipe advances together; it only freezes on a refused result.
    assign adv_en = !out_valid_q || out_ready;

    // Partial-product row j, shifted into place, with Baugh-Wooley inversion
    // of the bits where exactly one operand index is the sign position.
    function automatic logic [PW-1:0] pp_row(input logic [N-1:0] av, input logic bj,
                                             input int j, input logic sgn);
        logic [N-1:0] bits;
        bits = av & {N{bj}};
        if (sgn) begin
            bits = bits ^ ((j == N - 1) ? ~C_MSB : C_MSB);
        end
        return {{N{1'b0}}, bits} << j;
    endfunction

    generate
        for (genvar g = 0; g < S; g++) begin : g_stage
            localparam int FIRST = g * RPS + 1;
            localparam int LAST  = (FIRST + RPS - 1 < N - 1) ? FIRST + RPS - 1 : N - 1;

            logic [PW-1:0]    src_s;
            logic [PW-1:0]    src_c;
            logic [N-1:0]     src_a;
            logic [N-1:FIRST] src_b;
            logic             src_sgn;
            logic             src_vld;
            logic [TAG_W-1:0] src_tag;
            logic [PW-1:0]    sum_d;
            logic [PW-1:0]    carry_d;
            logic [PW-1:0]    pr;
            logic [PW-1:0]    nxt;
            logic [PW-1:0]    sum_q;
            logic [PW-1:0]    carry_q;
            logic [TAG_W-1:0] tag_q;
            logic             vld_q;

            if (g == 0) begin : g_src_in
                // Row 0 seeds the sum; the signed-mode constants seed the carry.
                assign src_s   = pp_row(a, b[0], 0, is_signed);
                assign src_c   = is_signed ? C_BW : '0;
                assign src_a   = a;
                assign src_b   = b[N-1:1];
                assign src_sgn = is_signed;
                assign src_vld = in_valid;
                assign src_tag = in_tag;
            end else begin : g_src_prev
                assign src_s   = g_stage[g-1].sum_q;
                assign src_c   = g_stage[g-1].carry_q;
                assign src_a   = g_stage[g-1].g_fwd.a_q;
                assign src_b   = g_stage[g-1].g_fwd.b_q;
                assign src_sgn = g_stage[g-1].g_fwd.sgn_q;
                assign src_vld = g_stage[g-1].vld_q;
                assign src_tag = g_stage[g-1].tag_q;
            end

            always_comb begin
                sum_d   = src_s;
                carry_d = src_c;
                pr      = '0;
                nxt     = '0;
                for (int r = FIRST; r <= LAST; r++) begin
                    pr      = pp_row(src_a, src_b[r], r, src_sgn);
                    nxt     = sum_d ^ carry_d ^ pr;
                    carry_d = ((sum_d & carry_d) | (sum_d & pr) | (carry_d & pr)) << 1;
                    sum_d   = nxt;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (adv_en) begin
                    vld_q <= src_vld;
                end
            end

            always_ff @(posedge clk) begin
                if (adv_en) begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    tag_q   <= src_tag;
                end
            end

            // Operands are only carried while rows remain to be reduced.
            if (g < S - 1) begin : g_fwd
                logic [N-1:0]      a_q;
                logic [N-1:LAST+1] b_q;
                logic              sgn_q;

                always_ff @(posedge clk) begin
                    if (adv_en) begin
                        a_q   <= src_a;
                        b_q   <= src_b[N-1:LAST+1];
                        sgn_q <= src_sgn;
                    end
                end
            end
        end
    endgenerate

    logic [PW-1:0] fin_s;
    logic [PW-1:0] fin_c;
    logic [PW-1:0] rip_sum;
    logic          rip_cy;

    assign fin_s = g_stage[S-1].sum_q;
    assign fin_c = g_stage[S-1].carry_q;

    always_comb begin
        rip_sum = '0;
        rip_cy  = 1'b0;
        for (int i = 0; i < PW; i++) begin
            rip_sum[i] = fin_s[i] ^ fin_c[i] ^ rip_cy;
            rip_cy     = (fin_s[i] & fin_c[i]) | (fin_s[i] & rip_cy) | (fin_c[i] & rip_cy);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            out_tag_q   <= '0;
        end else if (adv_en) begin
            out_valid_q <= g_stage[S-1].vld_q;
            if (g_stage[S-1].vld_q) begin
                p_q       <= rip_sum;
                out_tag_q <= g_stage[S-1].tag_q;
            end
        end
    end

    assign in_ready  = adv_en;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_array_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_array_mult
// Description : Scoreboard bench for pipe_array_mult (main N=8/RPS=2 instance
//               plus a parameter sweep of streaming instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_array_mult;
    localparam int N     = 8;
    localparam int RPS   = 2;
    localparam int TAG_W = 4;
    localparam int L     = (N + RPS - 2) / RPS + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             sw_rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             is_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   p;
    logic [TAG_W-1:0] out_tag;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit lat_en   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]      p;
        logic [TAG_W-1:0] tag;
        int               acc;
        bit               lat;
    } exp_t;
    exp_t exp_q[$];

    pipe_array_mult #(.N(N), .RPS(RPS), .TAG_W(TAG_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .out_tag  (out_tag)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input logic s, input int w);
        longint      xe;
        longint      ye;
        logic [63:0] pr;
        xe = longint'(x);
        ye = longint'(y);
        if (s && x[w-1]) xe = xe - (longint'(1) << w);
        if (s && y[w-1]) ye = ye - (longint'(1) << w);
        pr = 64'(xe * ye);
        return pr & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Latency counts edges from the presentation cycle, capture edge included.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("p", 64'(p), e.p);
                    check_eq("out_tag", 64'(out_tag), 64'(e.tag));
                    if (e.lat) check_eq("latency", 64'(cyc - e.acc), 64'(L));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{ref_mul(64'(a), 64'(b), is_signed, N), in_tag, cyc, lat_en});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that took the op.
    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic s, input logic [TAG_W-1:0] t);
        int guard;
        guard     = 0;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        is_signed = s;
        in_tag    = t;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check_eq("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        sw_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 sw_rst = 1'b0;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
            localparam int CN = (gi < 2) ? 4 : ((gi == 2) ? 8 : 16);
            localparam int CR = (gi == 0) ? 1 : ((gi == 1) ? 3 : ((gi == 2) ? 7 : 4));
            localparam int CL = (CN + CR - 2) / CR + 1;
            localparam int XW = 2 * CN + 1;

            logic            s_iv;
            logic            s_ir;
            logic            s_sg;
            logic            s_ov;
            logic [CN-1:0]   s_a;
            logic [CN-1:0]   s_b;
            logic [2*CN-1:0] s_p;
            logic [3:0]      s_it;
            logic [3:0]      s_ot;
            logic [63:0]     sq_p[$];
            logic [3:0]      sq_t[$];
            int              sq_c[$];
            bit              done = 1'b0;

            pipe_array_mult #(.N(CN), .RPS(CR), .TAG_W(4)) u_sw (
                .clk      (clk),
                .rst      (sw_rst),
                .in_valid (s_iv),
                .in_ready (s_ir),
                .a        (s_a),
                .b        (s_b),
                .is_signed(s_sg),
                .in_tag   (s_it),
                .out_valid(s_ov),
                .out_ready(1'b1),
                .p        (s_p),
                .out_tag  (s_ot)
            );

            always @(negedge clk) begin
                if (!sw_rst) begin
                    if (s_ov) begin
                        if (sq_p.size() == 0) begin
                            check_eq("sw_unexpected", 64'd1, 64'd0);
                        end else begin
                            check_eq("sw_p", 64'(s_p), sq_p.pop_front());
                            check_eq("sw_tag", 64'(s_ot), 64'(sq_t.pop_front()));
                            check_eq("sw_latency", 64'(cyc - sq_c.pop_front()), 64'(CL));
                        end
                    end
                    if (s_iv && s_ir) begin
                        sq_p.push_back(ref_mul(64'(s_a), 64'(s_b), s_sg, CN));
                        sq_t.push_back(s_it);
                        sq_c.push_back(cyc);
                    end
                end
            end

            initial begin
                int guard;
                s_iv = 1'b0;
                s_a  = '0;
                s_b  = '0;
                s_sg = 1'b0;
                s_it = '0;
                while (sw_rst) @(posedge clk);
                #1;
                if (CN == 4) begin
                    for (int i = 0; i < 512; i++) begin
                        s_iv = 1'b1;
                        {s_sg, s_a, s_b} = XW'(i);
                        s_it = 4'(i);
                        @(posedge clk);
                        #1;
                    end
                end else begin
                    for (int i = 0; i < 200; i++) begin
                        s_iv = 1'b1;
                        s_a  = CN'($urandom);
                        s_b  = CN'($urandom);
                        s_sg = i[0];
                        s_it = 4'(i);
                        @(posedge clk);
                        #1;
                    end
                end
                s_iv  = 1'b0;
                guard = 0;
                while (sq_p.size() != 0 && guard < 100) begin
                    @(posedge clk);
                    guard++;
                end
                #1;
                check_eq("sw_drain", 64'(sq_p.size()), 64'd0);
                done = 1'b1;
            end
        end
    endgenerate

    logic [N-1:0] ca [6] = '{8'h80, 8'd200, 8'hFF, 8'd200, 8'h80, 8'd200};
    logic [N-1:0] cb [6] = '{8'h80, 8'd3,   8'h01, 8'd3,   8'h7F, 8'd3};
    logic         cs [6] = '{1'b1,  1'b0,   1'b1,  1'b0,   1'b1,  1'b0};

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_p", 64'(p), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        send(8'd255, 8'd255, 1'b0, 4'd5);
        wait_drain("drain_first");

        for (int i = 0; i < 6; i++) send(ca[i], cb[i], cs[i], 4'(i + 8));
        wait_drain("drain_corners");

        for (int i = 0; i < 64; i++) send(8'($urandom), 8'($urandom), i[0], 4'(i));
        wait_drain("drain_random");

        // Back-pressure: fill, then refuse the head result while a new op waits.
        lat_en    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'($urandom_range(1, 255)), 8'(i + 7), i[0], 4'(i + 1));
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check_eq("stall_fill", 64'(out_valid), 64'd1);
        in_valid  = 1'b1;
        a         = 8'd99;
        b         = 8'd77;
        is_signed = 1'b0;
        in_tag    = 4'd12;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            check_eq("stall_p", 64'(p), exp_q[0].p);
            check_eq("stall_tag", 64'(out_tag), 64'(exp_q[0].tag));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain("drain_stall");
        lat_en = 1'b1;

        // Reset with ops in flight; only post-reset ops may emerge.
        for (int i = 0; i < 3; i++) send(8'(i + 20), 8'(i + 30), 1'b0, 4'(i + 3));
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_p", 64'(p), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(8'hC3, 8'h5A, 1'b1, 4'd9);
        send(8'd17, 8'd19, 1'b0, 4'd10);
        wait_drain("drain_reset");
        repeat (L + 2) @(posedge clk);

        guard = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
               && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        check_eq("sweep_done", 64'(guard < 3000), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
